mult_div_unit: RTL and testbench

//  - Multi-cycle multiply/divide unit with the HI/LO register pair, in the EX stage beside the ALU.
//  - Sequences mult/multu/div/divu with a fixed-latency busy counter and handles mthi/mtlo.
//  - Drives busy so the hazard unit can stall MD-class instructions in D.
//  - Result computation is behavioural; this block owns sequencing, commit timing and HI/LO state.

---
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Results are computed at accept, held as a pending pair, and committed to HI/LO
// together when the fixed-latency busy counter expires.
// Optional feature macro: MDU_MADD_EN. When defined, MADD/MADDU accumulate into {hi,lo}.
// When undefined, those opcodes behave as NONE.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } mdOpT;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  counterReg;
  logic [31:0] pendHiReg;
  logic [31:0] pendLoReg;
  logic        pendValidReg;
  logic [31:0] hiReg;
  logic [31:0] loReg;

  logic isMul;
  logic isDiv;
  logic isMthi;
  logic isMtlo;
  logic signedOp;
`ifdef MDU_MADD_EN
  logic isMadd;
`endif

  // Decode the requested operation; undefined opcodes fall through as NONE.
  always_comb begin
    isMul    = 1'b0;
    isDiv    = 1'b0;
    isMthi   = 1'b0;
    isMtlo   = 1'b0;
    signedOp = 1'b0;
`ifdef MDU_MADD_EN
    isMadd   = 1'b0;
`endif
    case (mdOp)
      OP_MULT:  begin isMul = 1'b1; signedOp = 1'b1; end
      OP_MULTU: begin isMul = 1'b1; end
      OP_DIV:   begin isDiv = 1'b1; signedOp = 1'b1; end
      OP_DIVU:  begin isDiv = 1'b1; end
      OP_MTHI:  begin isMthi = 1'b1; end
      OP_MTLO:  begin isMtlo = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin isMul = 1'b1; isMadd = 1'b1; signedOp = 1'b1; end
      OP_MADDU: begin isMul = 1'b1; isMadd = 1'b1; end
`endif
      default:  begin end
    endcase
  end

  // Multiply path: sign- or zero-extend to 64 bits so one multiplier serves both forms.
  logic [63:0] extA;
  logic [63:0] extB;
  logic [63:0] product;
  logic [63:0] mulResult;
  assign extA    = {{32{signedOp & srcA[31]}}, srcA};
  assign extB    = {{32{signedOp & srcB[31]}}, srcB};
  assign product = extA * extB;
`ifdef MDU_MADD_EN
  assign mulResult = isMadd ? ({hiReg, loReg} + product) : product;
`else
  assign mulResult = product;
`endif

  // Divide path on magnitudes so the most-negative / -1 case wraps instead of overflowing.
  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] safeB;
  logic [31:0] quotMag;
  logic [31:0] remMag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        divByZero;
  assign negA      = signedOp & srcA[31];
  assign negB      = signedOp & srcB[31];
  assign magA      = negA ? (~srcA + 32'd1) : srcA;
  assign magB      = negB ? (~srcB + 32'd1) : srcB;
  assign divByZero = (srcB == 32'd0);
  assign safeB     = divByZero ? 32'd1 : magB;
  assign quotMag   = magA / safeB;
  assign remMag    = magA % safeB;
  assign quot      = (negA ^ negB) ? (~quotMag + 32'd1) : quotMag;
  assign rem       = negA ? (~remMag + 32'd1) : remMag;

  // Sequencing: accept when idle, count down while running, commit on the last busy edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      counterReg   <= 4'd0;
      pendHiReg    <= 32'd0;
      pendLoReg    <= 32'd0;
      pendValidReg <= 1'b0;
      hiReg        <= 32'd0;
      loReg        <= 32'd0;
    end else if (counterReg != 4'd0) begin
      if (counterReg == 4'd1 && pendValidReg) begin
        hiReg <= pendHiReg;
        loReg <= pendLoReg;
      end
      counterReg <= counterReg - 4'd1;
    end else if (start) begin
      if (isMul) begin
        pendHiReg    <= mulResult[63:32];
        pendLoReg    <= mulResult[31:0];
        pendValidReg <= 1'b1;
        counterReg   <= MULT_LOAD;
      end else if (isDiv) begin
        pendHiReg    <= rem;
        pendLoReg    <= quot;
        pendValidReg <= ~divByZero;
        counterReg   <= DIV_LOAD;
      end else if (isMthi) begin
        hiReg <= srcA;
      end else if (isMtlo) begin
        loReg <= srcA;
      end
    end
  end

  assign busy = (counterReg != 4'd0);
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int errorCount = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdOp  (mdOp),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op, corrupt the operands after accept, check busy and commit.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int cycles,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    start = 1'b1; mdOp = op; srcA = a; srcB = b;
    tick();
    start = 1'b0; srcA = ~a; srcB = ~b;
    for (int i = 0; i < cycles; i++) begin
      checkVal({tag, " busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    checkVal({tag, " idle"}, {31'd0, busy}, 32'd0);
    checkVal({tag, " hi"}, hi, expHi);
    checkVal({tag, " lo"}, lo, expLo);
  endtask

  // Single-cycle op (MTHI/MTLO or a no-effect opcode).
  task automatic oneShot(input logic [3:0] op, input logic [31:0] a);
    start = 1'b1; mdOp = op; srcA = a; srcB = 32'd0;
    tick();
    start = 1'b0; mdOp = 4'd0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdOp = 4'd0; srcA = 32'd0; srcB = 32'd0;
    tick(); tick();
    reset = 1'b0;
    checkVal("reset busy", {31'd0, busy}, 32'd0);
    checkVal("reset hi", hi, 32'd0);
    checkVal("reset lo", lo, 32'd0);

    runOp("MULT -1*2", 4'd1, 32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runOp("MULTU", 4'd2, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE);
    runOp("MULT -3*-5", 4'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5, 32'h00000000, 32'h0000000F);
    runOp("DIV -7/2", 4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("DIVU 7/0", 4'd4, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("DIV 7/-2", 4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    runOp("DIV min/-1", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    // Start while busy is ignored: MTHI pulsed during a DIVU 100/7.
    start = 1'b1; mdOp = 4'd4; srcA = 32'd100; srcB = 32'd7;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; mdOp = 4'd5; srcA = 32'h00001234;
    tick();
    start = 1'b0; mdOp = 4'd0;
    for (int i = 0; i < 8; i++) tick();
    checkVal("DIVU 100/7 idle", {31'd0, busy}, 32'd0);
    checkVal("ignored MTHI hi", hi, 32'd2);
    checkVal("DIVU 100/7 lo", lo, 32'd14);

    // First idle cycle: MTLO accepted with no dead cycle, never busy.
    oneShot(4'd6, 32'h0000ABCD);
    checkVal("MTLO busy", {31'd0, busy}, 32'd0);
    checkVal("MTLO lo", lo, 32'h0000ABCD);
    checkVal("MTLO hi kept", hi, 32'd2);
    oneShot(4'd5, 32'h00005555);
    checkVal("MTHI hi", hi, 32'h00005555);

    // Back-to-back multiply directly after a single-cycle op.
    runOp("MULTU 3*4", 4'd2, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    runOp("MULT b2b", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    // Opcode above 8 has no effect.
    oneShot(4'd9, 32'h77777777);
    checkVal("op9 busy", {31'd0, busy}, 32'd0);
    checkVal("op9 hi", hi, 32'd0);
    checkVal("op9 lo", lo, 32'd42);

`ifdef MDU_MADD_EN
    oneShot(4'd5, 32'd0);
    oneShot(4'd6, 32'hFFFFFFFF);
    runOp("MADDU 1*1", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    runOp("MADD -1*1", 4'd7, 32'hFFFFFFFF, 32'd1, 5, 32'd0, 32'hFFFFFFFF);
`else
    oneShot(4'd7, 32'd1);
    checkVal("op7 busy", {31'd0, busy}, 32'd0);
    checkVal("op7 hi", hi, 32'd0);
    checkVal("op7 lo", lo, 32'd42);
`endif

    // Reset in busy cycle 4 of a DIV aborts it with no later commit.
    start = 1'b1; mdOp = 4'd3; srcA = 32'd100; srcB = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checkVal("pre-abort busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("abort busy", {31'd0, busy}, 32'd0);
    checkVal("abort hi", hi, 32'd0);
    checkVal("abort lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    checkVal("abort later busy", {31'd0, busy}, 32'd0);
    checkVal("abort later hi", hi, 32'd0);
    checkVal("abort later lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
